// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, forwarding selects
// and the multiplier sequencer states.
package ex_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/ex_mem_stage_mc_iter_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first,
// producing the low DATA_W bits of the product.
module iter_mul
    import ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] p
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    mul_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mcand_q, mplier_q, acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = ((state_q == IDLE) && start) || (state_q == BUSY);
        done = (state_q == DONE);
        p    = acc_q;
    end

    // Datapath needs no reset: the start cycle always reloads it.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
        end else if (state_q == BUSY) begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

endmodule

// File: rtl/ex_mem_stage_mc.sv
// Execute stage with forwarding, single-cycle ALU, iterative MUL and the
// EX/MEM pipeline register.
module ex_mem_stage_mc
    import ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic              MemWriteE,
    input  logic              ALUSrcE,
    input  logic              RegDstE,
    input  logic              MulE,
    input  logic [2:0]        ALUControlE,
    input  logic [DATA_W-1:0] RD1_E,
    input  logic [DATA_W-1:0] RD2_E,
    input  logic [DATA_W-1:0] SignImmE,
    input  logic [DATA_W-1:0] ResultW,
    input  logic [REG_AW-1:0] RsE,
    input  logic [REG_AW-1:0] RtE,
    input  logic [REG_AW-1:0] RdE,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic              FlushE,
    output logic              StallE,
    output logic              RegWriteM,
    output logic              MemtoRegM,
    output logic              MemWriteM,
    output logic [DATA_W-1:0] ALUOutM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [REG_AW-1:0] WriteRegM,
    output logic [REG_AW-1:0] RsE_out
);

    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] reg_val,
        input logic [DATA_W-1:0] wb_val,
        input logic [DATA_W-1:0] mem_val
    );
        case (sel)
            FWD_WB:  return wb_val;
            FWD_MEM: return mem_val;
            default: return reg_val;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] alu(
        input logic [2:0]               op,
        input logic signed [DATA_W-1:0] x,
        input logic signed [DATA_W-1:0] y
    );
        case (op)
            ALU_AND: return x & y;
            ALU_OR:  return x | y;
            ALU_ADD: return x + y;
            ALU_SUB: return x - y;
            ALU_SLT: return (x < y) ? DATA_W'(1) : '0;
            default: return '0;
        endcase
    endfunction

    logic signed [DATA_W-1:0] src_a, src_b;
    logic [DATA_W-1:0]        write_data, alu_result, alu_out;
    logic [REG_AW-1:0]        write_reg;
    logic                     mul_busy, mul_done;
    logic [DATA_W-1:0]        mul_p;
    logic                     bubble;

    always_comb begin
        src_a      = fwd_sel(ForwardAE, RD1_E, ResultW, ALUOutM);
        write_data = fwd_sel(ForwardBE, RD2_E, ResultW, ALUOutM);
        src_b      = ALUSrcE ? SignImmE : write_data;
        write_reg  = RegDstE ? RdE : RtE;
        alu_result = alu(ALUControlE, src_a, src_b);
        alu_out    = mul_done ? mul_p : alu_result;
    end

    iter_mul #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (MulE),
        .a     (src_a),
        .b     (src_b),
        .abort (FlushE),
        .busy  (mul_busy),
        .done  (mul_done),
        .p     (mul_p)
    );

    // Flush and reset both override a multiply in progress.
    assign StallE  = mul_busy && !FlushE && rst_n;
    assign bubble  = StallE || FlushE;
    assign RsE_out = RsE;

    // EX/MEM boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ALUOutM    <= '0;
            WriteDataM <= '0;
            WriteRegM  <= '0;
        end else if (bubble) begin
            RegWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ALUOutM    <= '0;
            WriteDataM <= '0;
            WriteRegM  <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemtoRegM  <= MemtoRegE;
            MemWriteM  <= MemWriteE;
            ALUOutM    <= alu_out;
            WriteDataM <= write_data;
            WriteRegM  <= write_reg;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage_mc.sv
// Directed bench for ex_mem_stage_mc (DATA_W=32): reset, ALU ops, forwarding,
// multi-cycle MUL timing, operand latching and flush.
module tb_ex_mem_stage_mc;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk, rst_n;
    logic          RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, MulE;
    logic [2:0]    ALUControlE;
    logic [DW-1:0] RD1_E, RD2_E, SignImmE, ResultW;
    logic [AW-1:0] RsE, RtE, RdE;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          FlushE;
    logic          StallE, RegWriteM, MemtoRegM, MemWriteM;
    logic [DW-1:0] ALUOutM, WriteDataM;
    logic [AW-1:0] WriteRegM, RsE_out;

    int passes = 0;
    int total  = 0;
    int stall_cnt, bubble_cnt;

    ex_mem_stage_mc #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .MulE(MulE),
        .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .SignImmE(SignImmE), .ResultW(ResultW),
        .RsE(RsE), .RtE(RtE), .RdE(RdE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .FlushE(FlushE),
        .StallE(StallE), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .MemWriteM(MemWriteM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .WriteRegM(WriteRegM), .RsE_out(RsE_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic src, input logic mul);
        ALUControlE = op; RD1_E = a; RD2_E = b; ALUSrcE = src; MulE = mul;
    endtask

    // Counts stall cycles and following M bubbles until StallE drops (bounded).
    task automatic run_mul();
        stall_cnt  = 0;
        bubble_cnt = 0;
        while (StallE === 1'b1 && stall_cnt < 100) begin
            stall_cnt++;
            step();
            if (RegWriteM === 1'b0 && ALUOutM === '0) bubble_cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0; FlushE = 1'b0;
        RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0; ALUSrcE = 0; RegDstE = 0; MulE = 0;
        ALUControlE = 3'b000; RD1_E = '0; RD2_E = '0; SignImmE = '0; ResultW = '0;
        RsE = '0; RtE = '0; RdE = '0; ForwardAE = 2'b00; ForwardBE = 2'b00;
        #1;
        check("reset_aluout", ALUOutM, 32'h0);
        check("reset_stall", {31'b0, StallE}, 32'h0);
        step();
        rst_n = 1'b1;

        // ADD 8+8 -> ALUOutM = 0x10
        RegWriteE = 1; RegDstE = 1; RdE = 5'd3; RtE = 5'd4; RsE = 5'd9;
        set_op(3'b010, 32'h8, 32'h8, 1'b0, 1'b0);
        #1 check("rs_copy", {27'b0, RsE_out}, 32'd9);
        step();
        check("add_result", ALUOutM, 32'h10);
        check("add_regwrite", {31'b0, RegWriteM}, 32'h1);
        check("add_writereg", {27'b0, WriteRegM}, 32'd3);

        // ADD with ForwardAE=10: ALUOutM(0x10) + 5
        ForwardAE = 2'b10;
        set_op(3'b010, 32'hDEAD, 32'h5, 1'b0, 1'b0);
        step();
        check("add_fwd_mem", ALUOutM, 32'h15);
        check("add_fwd_wdata", WriteDataM, 32'h5);
        ForwardAE = 2'b00;

        // Asynchronous reset with nonzero M registers and MulE pending
        MulE = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_aluout", ALUOutM, 32'h0);
        check("async_rst_regwrite", {31'b0, RegWriteM}, 32'h0);
        check("async_rst_stall", {31'b0, StallE}, 32'h0);
        MulE = 1'b0;
        step();
        rst_n = 1'b1;

        // SLT signed: -1 < 1 via immediate; RegDst=0 selects Rt; store flag
        RegDstE = 0; MemWriteE = 1; SignImmE = 32'h1;
        set_op(3'b111, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        step();
        check("slt_neg", ALUOutM, 32'h1);
        check("slt_writereg_rt", {27'b0, WriteRegM}, 32'd4);
        check("slt_memwrite", {31'b0, MemWriteM}, 32'h1);
        MemWriteE = 0; RegDstE = 1;

        set_op(3'b110, 32'h0, 32'h1, 1'b0, 1'b0);
        step();
        check("sub_wrap", ALUOutM, 32'hFFFF_FFFF);
        set_op(3'b000, 32'hF0F0, 32'hFF00, 1'b0, 1'b0);
        step();
        check("and", ALUOutM, 32'hF000);
        set_op(3'b001, 32'hF0F0, 32'hFF00, 1'b0, 1'b0);
        step();
        check("or", ALUOutM, 32'hFFF0);
        set_op(3'b011, 32'hF0F0, 32'hFF00, 1'b0, 1'b0);
        step();
        check("unused_op", ALUOutM, 32'h0);

        // ForwardBE=01 feeds ResultW as store data and SrcB
        ResultW = 32'h20; ForwardBE = 2'b01;
        set_op(3'b010, 32'h1, 32'h7, 1'b0, 1'b0);
        step();
        check("add_fwd_wb_b", ALUOutM, 32'h21);
        check("wdata_fwd_wb", WriteDataM, 32'h20);
        ForwardBE = 2'b00;

        // MUL 0x12345678 * 9
        RdE = 5'd7;
        set_op(3'b010, 32'h1234_5678, 32'h9, 1'b0, 1'b1);
        #1 check("mul_start_stall", {31'b0, StallE}, 32'h1);
        run_mul();
        check("mul_stall_cycles", stall_cnt, 32'd33);
        check("mul_bubbles", bubble_cnt, 32'd33);
        check("mul_done_nostall", {31'b0, StallE}, 32'h0);
        step();
        MulE = 1'b0;
        check("mul_product", ALUOutM, 32'hA3D7_0A38);
        check("mul_regwrite", {31'b0, RegWriteM}, 32'h1);
        check("mul_writereg", {27'b0, WriteRegM}, 32'd7);

        // Operand latch: ResultW changes during BUSY are ignored
        ForwardAE = 2'b01; ResultW = 32'h6;
        set_op(3'b010, 32'h0, 32'h7, 1'b0, 1'b1);
        step();
        ResultW = 32'h64;
        ForwardAE = 2'b10;
        run_mul();
        check("latch_stall_cycles", stall_cnt, 32'd32);
        step();
        MulE = 1'b0; ForwardAE = 2'b00;
        check("latch_product", ALUOutM, 32'd42);

        // Flush on the 10th BUSY cycle
        set_op(3'b010, 32'h3, 32'h5, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step();
        #1 check("pre_flush_stall", {31'b0, StallE}, 32'h1);
        FlushE = 1'b1;
        #1 check("flush_stall_low", {31'b0, StallE}, 32'h0);
        step();
        FlushE = 1'b0;
        check("flush_bubble_rw", {31'b0, RegWriteM}, 32'h0);
        check("flush_bubble_out", ALUOutM, 32'h0);
        set_op(3'b010, 32'h2, 32'h3, 1'b0, 1'b0);
        #1 check("post_flush_idle", {31'b0, StallE}, 32'h0);
        step();
        check("post_flush_add", ALUOutM, 32'h5);
        check("post_flush_rw", {31'b0, RegWriteM}, 32'h1);

        // Flush of an ordinary instruction yields a bubble
        FlushE = 1'b1;
        set_op(3'b010, 32'h2, 32'h3, 1'b0, 1'b0);
        step();
        FlushE = 1'b0;
        check("flush_add_bubble", ALUOutM, 32'h0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
